seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential restoring divider, the inverse of the team's 24x24 shift-add sequential multiplier.
- Takes a 2N-bit dividend and an N-bit divisor and produces an N-bit quotient and an N-bit remainder.
- Uses one trial-subtract per cycle.
- Controller and datapath live in one module with a start/done handshake.
- Sits beside the multiplier, so a multiplier product can be fed back to recover an operand.

Parameters:
- N, 24, operand width. Dividend is 2N bits; divisor, quotient and remainder are N bits each.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a division. Sampled only in IDLE.
- dividend  input  2N  numerator. Captured on the accepted start edge.
- divisor  input  N  denominator. Captured on the accepted start edge.
- quotient  output  N  quotient register.
- remainder  output  N  remainder register.
- busy  output  1  high in CHECK and CALC.
- done  output  1  one-cycle pulse; results are valid on this pulse.
- div_by_zero  output  1  error flag for the last operation.
- overflow  output  1  error flag: quotient does not fit in N bits.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - quotient, remainder, done, busy, div_by_zero and overflow all go to 0.
  - Iteration counter goes to 0.
  - Reset takes priority over every other event, including mid-CALC; a partial result is discarded and is never presented.
- Internal registers:
  - R (N bits): partial remainder.
  - Q (N bits): dividend low half, which becomes the quotient.
  - D (N bits): divisor.
  - cnt: iteration counter, ceil(log2(N+1)) bits.
- IDLE:
  - busy=0.
  - On start=1: R<=dividend[2N-1:N], Q<=dividend[N-1:0], D<=divisor; go to CHECK.
  - On start=0: stay in IDLE.
- CHECK (1 cycle), first matching rule wins:
  - D==0: set error result div_by_zero=1, overflow=0; go to DONE.
  - R>=D (unsigned): set error result overflow=1, div_by_zero=0; go to DONE.
  - Otherwise: cnt<=N; go to CALC.
- CALC (exactly N cycles), each cycle:
  - P = {R, Q[N-1]} (N+1 bits).
  - T = P - {1'b0, D} (N+1 bits).
  - If T[N]==0 (no borrow): R<=T[N-1:0], Q<={Q[N-2:0], 1'b1}.
  - Else: R<=P[N-1:0], Q<={Q[N-2:0], 1'b0}.
  - cnt<=cnt-1. Leave CALC when cnt reaches 1, loading quotient<=next Q, remainder<=next R, div_by_zero<=0, overflow<=0; go to DONE.
- Width rule: the CHECK precondition R<D guarantees R stays below D throughout. No bit is lost; P needs N+1 bits only transiently.
- Error result: quotient<={N{1'b1}}, remainder<=0, the matching flag set, loaded on the CHECK->DONE transition.
- DONE (1 cycle): done=1, busy=0; go unconditionally to IDLE.
- start during CHECK, CALC or DONE is ignored. A request is never queued.
- Output registers (quotient, remainder, flags) change only on entry to DONE or on reset. They hold their value through IDLE and through the next operation until its own DONE.
- Latency, counting the accepted start edge as edge 0:
  - Normal path: CHECK in cycle 1, CALC in cycles 2..N+1, done high in cycle N+2 (26 for N=24).
  - Error path: done high in cycle 2.
- Back-to-back: start may be asserted in the IDLE cycle immediately after DONE, giving a minimum period of N+3 cycles.
- No combinational path from inputs to outputs.

Test Plan:
- N=24, dividend=100, divisor=7, start for 1 cycle -> done in cycle 26 with quotient=14, remainder=2, flags=0; busy high in cycles 1..25.
- dividend=48'hFFFFFE000001, divisor=24'hFFFFFF -> quotient=24'hFFFFFF, remainder=0. Also dividend=48'hFFFFFEFFFFFF, same divisor -> quotient=24'hFFFFFF, remainder=24'hFFFFFE.
- divisor=0, any dividend -> done in cycle 2, div_by_zero=1, overflow=0, quotient=24'hFFFFFF, remainder=0. dividend=48'h000007000000, divisor=7 -> done in cycle 2, overflow=1.
- Round-trip, 1000 random pairs: feed A*B+r (from the multiplier model, with r<B, B!=0) -> quotient==A and remainder==r; flags clear.
- Pulse start again during CALC with different operands -> ignored; the first result is unchanged and exactly one done pulse occurs.
- Assert rst in cycle 10 of a division -> next cycle state is IDLE, all outputs 0, no done pulse. A new start afterwards completes normally with correct results.

Source files
------------

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake and result bus of the sequential divider.
//
// Handshake: the master holds dividend/divisor stable and raises start; the
// divider accepts it only on a rising edge where it is idle (busy=0, done=0).
// Requests seen while it is working are dropped, never queued. Results on
// quotient/remainder/div_by_zero/overflow are valid in the cycle that done is
// high and are held until the next operation completes or reset.
//
// Signals:
//   start        master->slave  request a division
//   dividend     master->slave  2N-bit numerator
//   divisor      master->slave  N-bit denominator
//   quotient     slave->master  N-bit quotient register
//   remainder    slave->master  N-bit remainder register
//   busy         slave->master  high while checking/iterating
//   done         slave->master  one-cycle completion pulse
//   div_by_zero  slave->master  last operation had divisor 0
//   overflow     slave->master  last quotient did not fit in N bits
//   dbg_state    slave->master  controller state (debug observation)
interface seq_divider_if #(parameter int N = 24);
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic           overflow;
  logic [1:0]     dbg_state;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow, dbg_state
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow, dbg_state
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, 2N-bit dividend by N-bit divisor,
// one trial subtraction per cycle. Companion of the shift-add multiplier: a
// product fed back here recovers the other operand.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, highest priority
//   bus  seq_divider_if.slave (start/dividend/divisor in; results, busy,
//        done, error flags and debug state out)
//
// Timing (accepted start edge = edge 0): CHECK in cycle 1, CALC in cycles
// 2..N+1, done in cycle N+2. Error cases finish with done in cycle 2.
// All outputs come from registers; there is no input-to-output comb path.
module seq_divider #(
  parameter int N = 24
) (
  input  logic        clk,
  input  logic        rst,
  seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_CALC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [N-1:0]     r_rem;       // partial remainder R
  logic [N-1:0]     r_q;         // dividend low half, shifts into quotient
  logic [N-1:0]     r_d;         // captured divisor
  logic [CNT_W-1:0] r_cnt;

  logic [N-1:0]     r_quotient;
  logic [N-1:0]     r_remainder;
  logic             r_dbz;
  logic             r_ovf;

  logic [N:0]       w_p;
  logic [N:0]       w_t;
  logic [N-1:0]     w_rem_next;
  logic [N-1:0]     w_q_next;
  logic             w_last;

  // One restoring step. R<D holds throughout, so P<2D and a non-borrowing
  // subtraction always leaves a result below D that fits back into N bits.
  assign w_p = {r_rem, r_q[N-1]};
  assign w_t = w_p - {1'b0, r_d};

  always_comb begin
    w_rem_next = w_p[N-1:0];
    w_q_next   = {r_q[N-2:0], 1'b0};
    if (!w_t[N]) begin
      w_rem_next = w_t[N-1:0];
      w_q_next   = {r_q[N-2:0], 1'b1};
    end
  end

  assign w_last = (r_cnt == CNT_W'(1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_CHECK;
      S_CHECK: begin
        if ((r_d == '0) || (r_rem >= r_d)) w_state_next = S_DONE;
        else                               w_state_next = S_CALC;
      end
      S_CALC:  if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rem <= bus.dividend[2*N-1:N];
            r_q   <= bus.dividend[N-1:0];
            r_d   <= bus.divisor;
          end
        end
        S_CHECK: begin
          // Divide-by-zero is tested first so it wins over overflow.
          if (r_d == '0) begin
            r_quotient  <= '1;
            r_remainder <= '0;
            r_dbz       <= 1'b1;
            r_ovf       <= 1'b0;
          end else if (r_rem >= r_d) begin
            r_quotient  <= '1;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b1;
          end else begin
            r_cnt <= CNT_W'(N);
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_rem_next;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;
  assign bus.overflow    = r_ovf;
  assign bus.busy        = (r_state == S_CHECK) || (r_state == S_CALC);
  assign bus.done        = (r_state == S_DONE);
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider (N=24).
// Expected results are pushed into exp_q when an operation is driven and a
// monitor pops and compares them on every done pulse.
module tb_seq_divider;
  localparam int N = 24;
  localparam int W = 2 * N + 2;   // {quotient, remainder, div_by_zero, overflow}

  logic clk;
  logic rst;

  seq_divider_if #(.N(N)) bus ();

  seq_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_count = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division on the full 48-bit dividend.
  function automatic logic [W-1:0] ref_div(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
    logic [2*N-1:0] q;
    logic [2*N-1:0] r;
    if (dv == '0) return {{N{1'b1}}, {N{1'b0}}, 1'b1, 1'b0};
    q = dd / {{N{1'b0}}, dv};
    r = dd % {{N{1'b0}}, dv};
    if (q >= (48'd1 << N)) return {{N{1'b1}}, {N{1'b0}}, 1'b0, 1'b1};
    return {q[N-1:0], r[N-1:0], 1'b0, 1'b0};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (bus.done) begin
      logic [W-1:0] e;
      done_count++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", 64'(bus.done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("quotient",    64'(bus.quotient),    64'(e[W-1:N+2]));
        check_eq("remainder",   64'(bus.remainder),   64'(e[N+1:2]));
        check_eq("div_by_zero", 64'(bus.div_by_zero), 64'(e[1]));
        check_eq("overflow",    64'(bus.overflow),    64'(e[0]));
        check_eq("busy_in_done", 64'(bus.busy),       64'd0);
      end
    end
  end

  // ---------------- drivers ----------------
  // Called at a negedge; returns #1 after the accepting edge (edge 0).
  task automatic start_op(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
    bus.start    = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Waits from cycle k0 for done; checks latency, busy and the single pulse.
  // Returns at the negedge of the IDLE cycle following done.
  task automatic wait_done(input int k0, input int exp_lat, input bit chk_busy);
    int k;
    bit seen;
    k = k0;
    seen = 1'b0;
    while (!seen && k < 64) begin
      @(negedge clk);
      k++;
      if (bus.done) seen = 1'b1;
      else if (chk_busy) check_eq("busy", 64'(bus.busy), 64'd1);
    end
    check_eq("done_seen", 64'(seen), 64'd1);
    check_eq("latency", 64'(k), 64'(exp_lat));
    @(negedge clk);
    check_eq("done_pulse_width", 64'(bus.done), 64'd0);
    check_eq("idle_after_done", 64'(bus.dbg_state), 64'd0);
  endtask

  task automatic run_op(input logic [2*N-1:0] dd, input logic [N-1:0] dv, input bit chk_busy);
    logic [W-1:0] e;
    e = ref_div(dd, dv);
    exp_q.push_back(e);
    start_op(dd, dv);
    wait_done(0, (e[1] || e[0]) ? 2 : N + 2, chk_busy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0]   a, b, r;
    logic [2*N-1:0] dd;
    int base;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    check_eq("rst_state",     64'(bus.dbg_state),   64'd0);
    check_eq("rst_quotient",  64'(bus.quotient),    64'd0);
    check_eq("rst_remainder", 64'(bus.remainder),   64'd0);
    check_eq("rst_busy",      64'(bus.busy),        64'd0);
    check_eq("rst_done",      64'(bus.done),        64'd0);
    check_eq("rst_dbz",       64'(bus.div_by_zero), 64'd0);
    check_eq("rst_ovf",       64'(bus.overflow),    64'd0);

    // Basic case with per-cycle busy checks.
    exp_q.push_back({24'd14, 24'd2, 1'b0, 1'b0});
    start_op(48'd100, 24'd7);
    wait_done(0, 26, 1'b1);
    check_eq("hold_quotient",  64'(bus.quotient),  64'd14);
    check_eq("hold_remainder", 64'(bus.remainder), 64'd2);

    // Full-scale boundaries, back-to-back with the previous operation.
    exp_q.push_back({24'hFFFFFF, 24'h000000, 1'b0, 1'b0});
    start_op(48'hFFFFFE000001, 24'hFFFFFF);
    wait_done(0, 26, 1'b0);
    exp_q.push_back({24'hFFFFFF, 24'hFFFFFE, 1'b0, 1'b0});
    start_op(48'hFFFFFEFFFFFF, 24'hFFFFFF);
    wait_done(0, 26, 1'b0);

    // Error paths.
    exp_q.push_back({24'hFFFFFF, 24'h0, 1'b1, 1'b0});
    start_op(48'h123456789ABC, 24'd0);
    wait_done(0, 2, 1'b1);
    exp_q.push_back({24'hFFFFFF, 24'h0, 1'b0, 1'b1});
    start_op(48'h000007000000, 24'd7);
    wait_done(0, 2, 1'b1);
    // Divisor zero with zero dividend still reports div_by_zero, not overflow.
    run_op(48'd0, 24'd0, 1'b0);

    // Just below the overflow threshold, and divide-by-one.
    run_op(48'h000006FFFFFF, 24'd7, 1'b0);
    run_op(48'h000000ABCDEF, 24'd1, 1'b0);
    run_op(48'h000001000000, 24'd1, 1'b0);

    // Start pulsed during CALC must be ignored.
    base = done_count;
    exp_q.push_back(ref_div(48'd5000, 24'd9));
    start_op(48'd5000, 24'd9);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 48'd777;
    bus.divisor = 24'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(5, 26, 1'b0);
    repeat (30) @(negedge clk);
    check_eq("single_done", 64'(done_count - base), 64'd1);

    // Reset in cycle 10 of a division discards it.
    base = done_count;
    start_op(48'd1000000, 24'd3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_state",     64'(bus.dbg_state),   64'd0);
    check_eq("midrst_quotient",  64'(bus.quotient),    64'd0);
    check_eq("midrst_remainder", 64'(bus.remainder),   64'd0);
    check_eq("midrst_busy",      64'(bus.busy),        64'd0);
    check_eq("midrst_flags",     64'({bus.div_by_zero, bus.overflow}), 64'd0);
    repeat (30) @(negedge clk);
    check_eq("midrst_no_done", 64'(done_count - base), 64'd0);
    run_op(48'd1000000, 24'd3, 1'b1);

    // Round trip through the multiplier model: (A*B + r) / B == A rem r.
    for (int i = 0; i < 1000; i++) begin
      a = 24'($urandom_range(0, 24'hFFFFFF));
      if (i % 4 == 0) b = 24'($urandom_range(1, 255));
      else            b = 24'($urandom_range(1, 24'hFFFFFF));
      r = 24'($urandom_range(0, 32'(b) - 1));
      dd = 48'(a) * 48'(b) + 48'(r);
      exp_q.push_back({a, r, 1'b0, 1'b0});
      start_op(dd, b);
      wait_done(0, 26, 1'b0);
    end

    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
